nibble_strobe_tx: RTL and testbench
===================================

# nibble_strobe_tx

Transmit side of the board's 4-bit strobed nibble link, the bus whose receive end double-flop synchronizes `data_async[3:0]` and `strobe_async[1:0]` into the stateful logic. This block accepts bytes on a ready/valid port, buffers them, and serializes each byte as two nibble beats. Data is held stable around a wide strobe pulse so an unsynchronized receiver with a two-flop synchronizer captures every beat exactly once. It sits in a source FPGA, or in the same top for loopback, and drives the receiver's pins directly.

## Interface
- `SETUP_CYCLES`, default 2: cycles data is stable before the strobe rises; ≥1.
- `STROBE_CYCLES`, default 4: cycles the strobe bit stays high; ≥3, so the receiver's synchronizer always sees it.
- `HOLD_CYCLES`, default 2: cycles data is held after the strobe falls; ≥1.
- `FIFO_DEPTH`, default 4: byte buffer depth; power of two, ≥2.
- `CLK`  in  1  sole clock, rising edge.
- `RST_N`  in  1  synchronous, active-low reset.
- `in_data`  in  8  byte to send; bits [7:4] go first.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  buffer can accept; reset 1.
- `data_out`  out  4  nibble to the link (drives `data_async`); reset 0.
- `strobe_out`  out  2  link strobes (drive `strobe_async`); reset 0.
- `busy`  out  1  FIFO non-empty or FSM not IDLE; reset 0.

One clock; reset is synchronous and active-low.

## Operation
- **Strobe encoding:**
  - `strobe_out` = 2'b01 marks the high-nibble beat.
  - 2'b10 marks the low-nibble beat.
  - 2'b00 means no beat.
  - 2'b11 never occurs.
- **FIFO:**
  - A push happens on any edge where `in_valid && in_ready`.
  - `in_ready` = !full and comes from the registered count only. There is no same-cycle pop bypass, so a full FIFO refuses a push even when a pop occurs that cycle.
  - Pointers wrap modulo `FIFO_DEPTH`.
- **FSM states:** IDLE, SETUP, STROBE, HOLD, plus a `nib` flag (0 = high nibble, 1 = low nibble).
  - IDLE → SETUP when the FIFO is non-empty. Pop the head, latch the byte, set `nib`=0, and drive `data_out` = byte[7:4].
  - SETUP → STROBE after `SETUP_CYCLES`. `strobe_out` = `nib` ? 2'b10 : 2'b01.
  - STROBE → HOLD after `STROBE_CYCLES`. `strobe_out` = 0 and `data_out` is unchanged.
  - HOLD, after `HOLD_CYCLES`, depends on `nib`:
    - `nib`=0: go to SETUP, set `nib`=1, drive `data_out` = byte[3:0].
    - `nib`=1 and FIFO non-empty: pop on the same edge and go to SETUP of the next byte with `nib`=0.
    - Otherwise: go to IDLE.
- `data_out` changes only on SETUP entry, never while a strobe bit is high. In IDLE it keeps its last value.
- A single down-counter, reloaded on every state entry, times all phases. Its width is clog2 of the largest parameter plus 1.
- Reset mid-byte: on the reset edge, FSM → IDLE, FIFO empties, `strobe_out`/`data_out` go to 0, and the partial byte is discarded. The receiver sees at most one truncated strobe pulse.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- For a push at edge t0 into an idle, empty block:
  - Pop and SETUP entry happen at t1, so `data_out` = high nibble from t1.
  - `strobe_out`=01 from t1+`SETUP_CYCLES`.
- Per byte: 2·(SETUP+STROBE+HOLD) cycles, 16 at defaults. Back-to-back bytes leave no idle gap.
- `busy` falls on the edge that enters IDLE with the FIFO empty.

## Structure
- Package `nibble_link_pkg`: strobe code constants (STB_NONE, STB_HI, STB_LO) and the FSM state enum. A future receiver/decoder shares the package.
- Sub-module `nibble_strobe_fifo`: synchronous FIFO, byte-wide, with `FIFO_DEPTH` parameter and push/pop/full/empty/count outputs. The FSM and counter stay in the top of this block.

## Test plan
- **Reset values:** hold `RST_N`=0 for 3 cycles → `in_ready`=1, `busy`=0, `data_out`=0, `strobe_out`=0.
- **Single byte:** push 0xA5 at t0 → from t1 `data_out`=0xA; `strobe_out`=01 for cycles t1+2..t1+5. Then `data_out`=0x5 from t1+8, `strobe_out`=10 for t1+10..t1+13, and IDLE at t1+16.
- **Back-to-back:** push 0x12, 0x34, 0x56 on consecutive cycles → nibble sequence 1,2,3,4,5,6 with strobes 01,10 alternating, no gaps, and exactly 48 cycles of `busy` after the first pop.
- **Full:** push 6 bytes with `in_valid` held high → `in_ready` low once 4 are buffered. Pushes resume without loss or duplication, including on a cycle where a pop and a blocked push coincide.
- **Reset mid-strobe:** assert `RST_N`=0 during the STROBE of the low nibble → next edge `strobe_out`=0 and the FIFO is empty. A subsequent push of 0xC3 transmits cleanly.
- **Loopback:** feed the outputs through a two-flop synchronizer at a 7/5 clock ratio and count rising strobe edges → exactly 2 per byte, with the captured nibbles equal to the sent bytes.

Source files
------------

// File: rtl/nibble_link_pkg.sv
// ============================================================================
// Module   : nibble_link_pkg
// Brief    : Strobe codes and FSM state type shared by the nibble link blocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

package nibble_link_pkg;

    localparam logic [1:0] STB_NONE = 2'b00;
    localparam logic [1:0] STB_HI   = 2'b01;
    localparam logic [1:0] STB_LO   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/nibble_strobe_fifo.sv
// ============================================================================
// Module   : nibble_strobe_fifo
// Brief    : Byte-wide synchronous FIFO with show-ahead read of the head entry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_strobe_fifo #(
    parameter  int FIFO_DEPTH = 4,
    localparam int AW         = $clog2(FIFO_DEPTH),
    localparam int CW         = AW + 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          push,
    input  logic [7:0]    wr_data,
    input  logic          pop,
    output logic [7:0]    rd_data,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_push;
    logic          w_pop;

    assign full    = (r_count == CW'(FIFO_DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign rd_data = r_mem[r_rd_ptr];

    // Guarded internally so a stray request can never corrupt the pointers.
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/nibble_strobe_tx.sv
// ============================================================================
// Module   : nibble_strobe_tx
// Brief    : Buffers bytes and sends them as two strobed nibble beats each.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nibble_strobe_tx
    import nibble_link_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int HOLD_CYCLES   = 2,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] data_out,
    output logic [1:0] strobe_out,
    output logic       busy
);

    localparam int MAX_A = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_P = (MAX_A > HOLD_CYCLES) ? MAX_A : HOLD_CYCLES;
    localparam int CNT_W = $clog2(MAX_P) + 1;
    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] c_setup_ld  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_strobe_ld = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_hold_ld   = CNT_W'(HOLD_CYCLES - 1);

    tx_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_nib, w_nib_nxt;
    logic [3:0]       r_lo, w_lo_nxt;
    logic [3:0]       r_data, w_data_nxt;
    logic [1:0]       r_strobe, w_strobe_nxt;
    logic             w_pop;
    logic             w_push;
    logic [7:0]       w_head;
    logic             w_full;
    logic             w_empty;
    logic [FCW-1:0]   w_count;

    // in_ready comes straight from the registered count: no pop bypass.
    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign data_out   = r_data;
    assign strobe_out = r_strobe;
    assign busy       = (r_state != ST_IDLE) || (w_count != '0);

    nibble_strobe_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .push    (w_push),
        .wr_data (in_data),
        .pop     (w_pop),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_nib    <= 1'b0;
            r_lo     <= '0;
            r_data   <= '0;
            r_strobe <= STB_NONE;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_nib    <= w_nib_nxt;
            r_lo     <= w_lo_nxt;
            r_data   <= w_data_nxt;
            r_strobe <= w_strobe_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = (r_cnt != '0) ? (r_cnt - CNT_W'(1)) : r_cnt;
        w_nib_nxt    = r_nib;
        w_lo_nxt     = r_lo;
        w_data_nxt   = r_data;
        w_strobe_nxt = r_strobe;
        w_pop        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SETUP;
                    w_cnt_nxt   = c_setup_ld;
                    w_nib_nxt   = 1'b0;
                    w_lo_nxt    = w_head[3:0];
                    w_data_nxt  = w_head[7:4];
                end
            end
            ST_SETUP: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_STROBE;
                    w_cnt_nxt    = c_strobe_ld;
                    w_strobe_nxt = r_nib ? STB_LO : STB_HI;
                end
            end
            ST_STROBE: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = ST_HOLD;
                    w_cnt_nxt    = c_hold_ld;
                    w_strobe_nxt = STB_NONE;
                end
            end
            ST_HOLD: begin
                if (r_cnt == '0) begin
                    if (!r_nib) begin
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = c_setup_ld;
                        w_nib_nxt   = 1'b1;
                        w_data_nxt  = r_lo;
                    end else if (!w_empty) begin
                        // Chain straight into the next byte with no idle gap.
                        w_pop       = 1'b1;
                        w_state_nxt = ST_SETUP;
                        w_cnt_nxt   = c_setup_ld;
                        w_nib_nxt   = 1'b0;
                        w_lo_nxt    = w_head[3:0];
                        w_data_nxt  = w_head[7:4];
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_nibble_strobe_tx.sv
// ============================================================================
// Module   : tb_nibble_strobe_tx
// Brief    : Directed self-checking bench for nibble_strobe_tx.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nibble_strobe_tx;

    logic       clk = 1'b0;
    logic       rclk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] data_out;
    logic [1:0] strobe_out;
    logic       busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;
    always #7 rclk = ~rclk;

    nibble_strobe_tx dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .data_out   (data_out),
        .strobe_out (strobe_out),
        .busy       (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected {busy, data_out, strobe_out} j cycles after the pop of byte b.
    function automatic logic [6:0] exp_single(input int j, input logic [7:0] b);
        int   p;
        logic hi;
        logic [3:0] n;
        logic [1:0] s;
        if (j >= 16) return {1'b0, b[3:0], 2'b00};
        p  = j % 8;
        hi = (j < 8);
        n  = hi ? b[7:4] : b[3:0];
        s  = (p >= 2 && p <= 5) ? (hi ? 2'b01 : 2'b10) : 2'b00;
        return {1'b1, n, s};
    endfunction

    // Beat monitor on the transmit clock: records data at each strobe rise.
    logic [1:0] mon_prev = 2'b00;
    logic [1:0] mon_code [256];
    logic [3:0] mon_nib  [256];
    int         mon_cnt = 0;

    always @(negedge clk) begin
        if (mon_prev == 2'b00 && strobe_out != 2'b00 && mon_cnt < 256) begin
            mon_code[mon_cnt] <= strobe_out;
            mon_nib[mon_cnt]  <= data_out;
            mon_cnt           <= mon_cnt + 1;
        end
        mon_prev <= strobe_out;
    end

    // Unrelated-clock receiver with a two-flop synchronizer.
    logic [5:0] rs1 = '0;
    logic [5:0] rs2 = '0;
    logic [1:0] rs_prev = '0;
    logic [1:0] rx_code [256];
    logic [3:0] rx_nib  [256];
    int         rx_cnt = 0;
    int         rx_rises = 0;

    always @(posedge rclk) begin
        rs1     <= {strobe_out, data_out};
        rs2     <= rs1;
        rs_prev <= rs2[5:4];
        if (rs2[4] && !rs_prev[0] && rx_cnt < 256) begin
            rx_code[rx_cnt] <= 2'b01;
            rx_nib[rx_cnt]  <= rs2[3:0];
            rx_cnt          <= rx_cnt + 1;
        end else if (rs2[5] && !rs_prev[1] && rx_cnt < 256) begin
            rx_code[rx_cnt] <= 2'b10;
            rx_nib[rx_cnt]  <= rs2[3:0];
            rx_cnt          <= rx_cnt + 1;
        end
        rx_rises <= rx_rises + ((rs2[4] && !rs_prev[0]) ? 1 : 0)
                             + ((rs2[5] && !rs_prev[1]) ? 1 : 0);
    end

    task automatic push_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check_eq("push_timeout", 32'(n), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < max);
        check_eq(tag, 32'(busy), 0);
    endtask

    task automatic check_beats(input int base, input logic [7:0] b, input string tag);
        check_eq({tag, "_hi"}, {26'd0, mon_code[base], mon_nib[base]}, {26'd0, 2'b01, b[7:4]});
        check_eq({tag, "_lo"}, {26'd0, mon_code[base+1], mon_nib[base+1]}, {26'd0, 2'b10, b[3:0]});
    endtask

    initial begin
        logic [7:0] b2b   [3];
        logic [7:0] fbytes[6];
        logic [7:0] lbytes[3];
        int         push_edge[6];
        int         base, busy_len, idx, n, rbase, rrise;
        logic       rdy;

        b2b    = '{8'h12, 8'h34, 8'h56};
        fbytes = '{8'h81, 8'h92, 8'hA3, 8'hB4, 8'hC5, 8'hD6};
        lbytes = '{8'h3C, 8'hF0, 8'h0F};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 1);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_data", 32'(data_out), 0);
        check_eq("rst_strobe", 32'(strobe_out), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
        base = mon_cnt;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("single_busy_t0", 32'(busy), 1);
        for (int j = 0; j <= 16; j++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq($sformatf("single_j%0d", j), {25'd0, busy, data_out, strobe_out},
                     {25'd0, exp_single(j, 8'hA5)});
        end
        check_eq("single_beats", 32'(mon_cnt - base), 2);
        check_beats(base, 8'hA5, "single");

        // Back-to-back 0x12, 0x34, 0x56
        repeat (2) @(negedge clk);
        base = mon_cnt;
        busy_len = 0;
        in_data  = b2b[0];
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_data = b2b[1];
        for (int j = 0; j <= 48; j++) begin
            @(posedge clk);
            @(negedge clk);
            if (j == 0) in_data = b2b[2];
            if (j == 1) in_valid = 1'b0;
            if (busy) busy_len++;
            if (j < 48)
                check_eq($sformatf("b2b_j%0d", j), {25'd0, busy, data_out, strobe_out},
                         {25'd0, exp_single(j % 16, b2b[j / 16])});
            else
                check_eq("b2b_end", {25'd0, busy, data_out, strobe_out}, {25'd0, 1'b0, 4'h6, 2'b00});
        end
        check_eq("b2b_busy_len", 32'(busy_len), 48);
        check_eq("b2b_beats", 32'(mon_cnt - base), 6);
        for (int i = 0; i < 3; i++) check_beats(base + 2 * i, b2b[i], $sformatf("b2b_%0d", i));

        // Full FIFO with in_valid held high
        repeat (2) @(negedge clk);
        base = mon_cnt;
        idx = 0;
        n = 0;
        while (idx < 6 && n < 100) begin
            @(negedge clk);
            in_data  = fbytes[idx];
            in_valid = 1'b1;
            rdy      = in_ready;
            if (n == 5) check_eq("full_ready_low", 32'(in_ready), 0);
            @(posedge clk);
            if (rdy) begin
                push_edge[idx] = n;
                idx++;
            end
            n++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("full_pushed", 32'(idx), 6);
        check_eq("full_push4_edge", 32'(push_edge[4]), 4);
        check_eq("full_resume_edge", 32'(push_edge[5]), 18);
        wait_idle(200, "full_idle");
        check_eq("full_beats", 32'(mon_cnt - base), 12);
        for (int i = 0; i < 6; i++) check_beats(base + 2 * i, fbytes[i], $sformatf("full_%0d", i));

        // Reset during the low-nibble strobe
        repeat (2) @(negedge clk);
        push_byte(8'h5A);
        n = 0;
        while (strobe_out != 2'b10 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check_eq("rmid_found_lo", 32'(strobe_out), 32'h2);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("rmid_strobe", 32'(strobe_out), 0);
        check_eq("rmid_data", 32'(data_out), 0);
        check_eq("rmid_busy", 32'(busy), 0);
        check_eq("rmid_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        base = mon_cnt;
        push_byte(8'hC3);
        wait_idle(40, "rmid_idle");
        check_eq("rmid_beats", 32'(mon_cnt - base), 2);
        check_beats(base, 8'hC3, "rmid");

        // Loopback through the asynchronous receiver
        repeat (10) @(negedge clk);
        rbase = rx_cnt;
        rrise = rx_rises;
        for (int i = 0; i < 3; i++) push_byte(lbytes[i]);
        wait_idle(100, "loop_idle");
        repeat (10) @(negedge clk);
        check_eq("loop_rises", 32'(rx_rises - rrise), 6);
        check_eq("loop_beats", 32'(rx_cnt - rbase), 6);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("loop_code_%0d", i),
                     {28'd0, rx_code[rbase + 2 * i], rx_code[rbase + 2 * i + 1]}, 32'h6);
            check_eq($sformatf("loop_byte_%0d", i),
                     {24'd0, rx_nib[rbase + 2 * i], rx_nib[rbase + 2 * i + 1]}, {24'd0, lbytes[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
